if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 32-bit MIPS core, directly upstream of IntructionMemory.
- Holds the PC and drives the memory address. Captures the returned instruction into the IF/ID pipeline register.
- Applies stall, branch and jump redirects.
- No branch delay slots: wrong-path fetches are squashed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, PC increment per sequential fetch (byte addressing, one 32-bit word per fetch).
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on reset or squash (sll $0,$0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- stall  input  1  hazard-unit freeze of PC and IF/ID (load-use).
- branch_taken  input  1  branch resolved taken; already qualified by the issuing stage.
- branch_target  input  32  full byte target of the taken branch.
- jump  input  1  J/JAL decoded in ID; qualified internally by if_id_valid.
- jump_index  input  26  instr[25:0] of the jump in ID.
- imem_addr  output  32  address to IntructionMemory; equals pc.
- imem_instr  input  32  combinational read data from IntructionMemory for imem_addr.
- pc  output  32  current fetch PC, for debug/trace.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc4  output  32  IF/ID PC+PC_INC of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Registers: pc, if_id_instr, if_id_pc4, if_id_valid. imem_addr = pc combinationally; there are no other combinational outputs.
- Fetch latency is 1 cycle. The word read at pc in cycle N appears on if_id_instr after edge N+1.
- Per-edge priority: reset > branch > jump > stall > advance.
- Reset (rst_n=0): pc<=RESET_PC, if_id_instr<=NOP_INSTR, if_id_pc4<=0, if_id_valid<=0.
  - Overrides every other input, including mid-redirect or mid-stall.
  - First valid IF/ID appears one edge after rst_n rises.
- Branch (branch_taken=1):
  - pc<=branch_target with bits [1:0] forced to 00.
  - IF/ID squashed: instr<=NOP_INSTR, pc4<=0, valid<=0.
  - Takes priority over stall and jump; branch is the older instruction.
- Jump (jump=1 and if_id_valid=1, no branch):
  - pc<={if_id_pc4[31:28], jump_index, 2'b00}.
  - IF/ID squashed as for branch.
  - Wins over stall. If if_id_valid=0, jump is ignored.
- Stall (no redirect): pc and all IF/ID registers hold, and imem_addr is unchanged. Multi-cycle stalls hold indefinitely.
- Advance: pc<=pc+PC_INC; if_id_instr<=imem_instr; if_id_pc4<=pc+PC_INC; if_id_valid<=1.
- Arithmetic: 32-bit unsigned modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Redirect on the cycle stall deasserts: redirect rules apply and there is no extra bubble.
- The block applies no other alignment check. The single jump/branch FSM is implicit (RUN, or SQUASH when valid=0); there is no explicit state register beyond if_id_valid.

Decomposition:
- Shared package mips_pkg: WORD_W=32, JIDX_W=26, NOP_INSTR constant, RESET_PC default.
- The next-PC mux is kept as sub-module pc_next_sel (combinational).
  - Inputs: pc, if_id_pc4, branch/jump controls.
  - Outputs: next_pc, squash.
- The top module holds the registers and the IF/ID capture.

Test Plan:
- Reset then run: rst_n low 2 cycles, memory word k = 32'h1000_0000+k. Expect:
  - imem_addr sequence 0,4,8,12.
  - if_id_valid 0 then 1.
  - if_id_instr 32'h1000_0000 with if_id_pc4=4 one edge after release.
- Stall: assert stall for 3 cycles at pc=8 → pc stays 8, if_id_instr/pc4 frozen at word for pc=4/8, resumes with pc=12 next edge.
- Branch: branch_taken=1, branch_target=32'h0000_0041 at pc=16 → pc=32'h0000_0040, if_id_valid=0, if_id_instr=0; next edge fetch from 0x40 is valid.
- Jump: if_id_pc4=32'h4000_0010, jump=1, jump_index=26'h000_0100 → pc=32'h4000_0400, IF/ID squashed. Same with if_id_valid=0 → ignored, pc advances by 4.
- Simultaneous: branch_taken=1 (target 0x80) + jump=1 + stall=1 → pc=0x80, squash. Also rst_n=0 together with branch_taken=1 → pc=RESET_PC, valid=0.
- Wrap: force pc to 32'hFFFF_FFFC by branch, advance → pc=0, if_id_pc4=0, if_id_valid=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and constants for the MIPS core pipeline.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned JIDX_W = 26;

    // sll $0,$0,0 -- the canonical bubble.
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC    = 32'd4;

endpackage : mips_pkg

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage.
// Priority: branch > jump (only when IF/ID is valid) > stall > sequential.
// squash is raised whenever a redirect discards the wrong-path fetch.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_INC_P = PC_INC
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] if_id_pc4,
    input  logic              if_id_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [WORD_W-1:0] next_pc,
    output logic              squash
);

    logic [WORD_W-1:0] branch_pc_s;
    logic [WORD_W-1:0] jump_pc_s;

    // Branch target is word-aligned by clearing the two low bits; the jump
    // keeps the 256 MB region of the instruction following the jump.
    assign branch_pc_s = branch_target & 32'hFFFF_FFFC;
    assign jump_pc_s   = (if_id_pc4 & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};

    // Select the next PC and flag a squash on any accepted redirect.
    always_comb begin
        next_pc = pc;
        squash  = 1'b0;
        if (branch_taken) begin
            next_pc = branch_pc_s;
            squash  = 1'b1;
        end else if (jump && if_id_valid) begin
            next_pc = jump_pc_s;
            squash  = 1'b1;
        end else if (stall) begin
            next_pc = pc;
            squash  = 1'b0;
        end else begin
            next_pc = pc + PC_INC_P;
            squash  = 1'b0;
        end
    end

endmodule : pc_next_sel

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and the
// IF/ID pipeline register. No delay slots: redirects squash IF/ID.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [WORD_W-1:0] PC_INC    = mips_pkg::PC_INC,
    parameter logic [WORD_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    logic [WORD_W-1:0] pc_r;
    logic [WORD_W-1:0] if_id_instr_r;
    logic [WORD_W-1:0] if_id_pc4_r;
    logic              if_id_valid_r;
    logic [WORD_W-1:0] next_pc_s;
    logic              squash_s;

    pc_next_sel #(
        .PC_INC_P (PC_INC)
    ) u_pc_next_sel (
        .pc            (pc_r),
        .if_id_pc4     (if_id_pc4_r),
        .if_id_valid   (if_id_valid_r),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .next_pc       (next_pc_s),
        .squash        (squash_s)
    );

    // PC and IF/ID update; reset overrides everything, then squash, stall, advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            if_id_instr_r <= NOP_INSTR;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
        end else begin
            pc_r <= next_pc_s;
            if (squash_s) begin
                if_id_instr_r <= NOP_INSTR;
                if_id_pc4_r   <= 32'h0000_0000;
                if_id_valid_r <= 1'b0;
            end else if (stall) begin
                if_id_instr_r <= if_id_instr_r;
                if_id_pc4_r   <= if_id_pc4_r;
                if_id_valid_r <= if_id_valid_r;
            end else begin
                // On advance next_pc_s is pc + PC_INC, the return address of this fetch.
                if_id_instr_r <= imem_instr;
                if_id_pc4_r   <= next_pc_s;
                if_id_valid_r <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc4   = if_id_pc4_r;
    assign if_id_valid = if_id_valid_r;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random stimulus, all
// checked against a behavioural model of the fetch stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    always #5 clk = ~clk;

    // Memory: word k holds 32'h1000_0000 + k.
    assign imem_instr = 32'h1000_0000 + (imem_addr / 32'd4);

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge.
    task automatic step(input logic r, input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [25:0] ji);
        logic [31:0] word;
        @(negedge clk);
        rst_n = r; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_index = ji;
        word = 32'h1000_0000 + (m_pc / 32'd4);
        if (!r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (br) begin
            m_pc = bt - (bt % 32'd4);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (j && m_valid) begin
            m_pc = (m_pc4 / 32'h1000_0000) * 32'h1000_0000 + {6'd0, ji} * 32'd4;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = word;
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    endtask

    task automatic adv();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_index = 26'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;

        // Reset, then sequential run.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        adv();
        chk("first_instr", if_id_instr, 32'h1000_0000);
        chk("first_pc4", if_id_pc4, 32'd4);
        adv();
        chk("pc_8", pc, 32'd8);

        // Three-cycle stall at pc=8.
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("stall_pc", pc, 32'd8);
        adv();
        chk("resume_pc", pc, 32'd12);
        adv();

        // Branch with unaligned target at pc=16.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0041, 1'b0, 26'h0);
        chk("branch_pc", pc, 32'h0000_0040);
        adv();
        chk("after_branch_valid", {31'd0, if_id_valid}, 32'd1);

        // Jump with if_id_pc4 = 0x4000_0010, then a jump while IF/ID is invalid.
        step(1'b1, 1'b0, 1'b1, 32'h4000_000C, 1'b0, 26'h0);
        adv();
        chk("jump_setup_pc4", if_id_pc4, 32'h4000_0010);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100);
        chk("jump_pc", pc, 32'h4000_0400);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100);
        chk("jump_ignored_pc", pc, 32'h4000_0404);

        // Branch + jump + stall together; then reset together with branch.
        adv();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 26'h3FF_FFFF);
        chk("simul_pc", pc, 32'h0000_0080);
        adv();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 26'h000_0010);
        chk("rst_branch_pc", pc, 32'h0);

        // Wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
        adv();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_valid", {31'd0, if_id_valid}, 32'd1);

        // Random stimulus.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom(),
                 ($urandom_range(0, 5) == 0),
                 26'($urandom()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_if_stage
